// File: rtl/e203_dtcm_init_pkg.sv
// rtl/e203_dtcm_init_pkg.sv - shared state, mode and limit definitions for the DTCM bulk initialiser
package e203_dtcm_init_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic MODE_FILL   = 1'b0;
  localparam logic MODE_VERIFY = 1'b1;

  // Outstanding-command ceiling and the counter width that covers it.
  localparam int unsigned OUTS_MAX = 4;
  localparam int unsigned OUTS_W   = 3;

endpackage

// File: rtl/e203_dtcm_init_gen.sv
// rtl/e203_dtcm_init_gen.sv - word index to (byte address, expected data) generator
module e203_dtcm_init_gen
  import e203_dtcm_init_pkg::*;
#(
  parameter int unsigned AW = 16,
  parameter int unsigned LW = 14
) (
  input  logic [AW-1:0] base_i,
  input  logic [LW-1:0] idx_i,
  input  logic [31:0]   pattern_i,
  input  logic          incr_i,
  output logic [AW-1:0] addr_o,
  output logic [31:0]   data_o
);

  logic [LW+1:0] byte_off;

  // Address arithmetic wraps naturally at the AW boundary.
  assign byte_off = {idx_i, 2'b00};
  assign addr_o   = base_i + AW'(byte_off);
  assign data_o   = incr_i ? (pattern_i + 32'(idx_i)) : pattern_i;

endmodule

// File: rtl/e203_dtcm_bulk_init.sv
// rtl/e203_dtcm_bulk_init.sv - ICB initiator that bulk-fills or read-verifies a DTCM word range
module e203_dtcm_bulk_init
  import e203_dtcm_init_pkg::*;
#(
  parameter int unsigned AW       = 16,
  parameter int unsigned LW       = 14,
  parameter int unsigned OUTS_NUM = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          cfg_mode,
  input  logic [AW-1:0] cfg_base,
  input  logic [LW-1:0] cfg_len,
  input  logic [31:0]   cfg_pattern,
  input  logic          cfg_incr,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          aborted,
  output logic [AW-1:0] err_addr,
  output logic [31:0]   err_rdata,
  output logic          icb_cmd_valid,
  input  logic          icb_cmd_ready,
  output logic [AW-1:0] icb_cmd_addr,
  output logic          icb_cmd_read,
  output logic [31:0]   icb_cmd_wdata,
  output logic [3:0]    icb_cmd_wmask,
  input  logic          icb_rsp_valid,
  output logic          icb_rsp_ready,
  input  logic          icb_rsp_err,
  input  logic [31:0]   icb_rsp_rdata
);

  state_e              state_q, state_d;
  logic                mode_q, incr_q;
  logic [AW-1:0]       base_q;
  logic [LW-1:0]       len_q, issued_q, retired_q;
  logic [31:0]         pattern_q;
  logic [OUTS_W-1:0]   outs_q, outs_d;
  logic                hold_q;
  logic                err_q, aborted_q;
  logic [AW-1:0]       err_addr_q;
  logic [31:0]         err_rdata_q;

  logic [AW-1:0]       iss_addr, ret_addr;
  logic [31:0]         iss_data, ret_data;
  logic                start_acc, can_issue, cmd_hs, rsp_hs, rsp_fail;

  e203_dtcm_init_gen #(.AW(AW), .LW(LW)) u_gen_issue (
    .base_i    (base_q),
    .idx_i     (issued_q),
    .pattern_i (pattern_q),
    .incr_i    (incr_q),
    .addr_o    (iss_addr),
    .data_o    (iss_data)
  );

  e203_dtcm_init_gen #(.AW(AW), .LW(LW)) u_gen_retire (
    .base_i    (base_q),
    .idx_i     (retired_q),
    .pattern_i (pattern_q),
    .incr_i    (incr_q),
    .addr_o    (ret_addr),
    .data_o    (ret_data)
  );

  assign start_acc = start && (state_q == ST_IDLE);
  assign can_issue = (state_q == ST_RUN) && (issued_q < len_q)
                     && (outs_q < OUTS_W'(OUTS_NUM)) && !abort;

  // hold_q keeps a presented command on the bus until accepted, even under abort.
  assign icb_cmd_valid = hold_q || can_issue;
  assign icb_cmd_addr  = iss_addr;
  assign icb_cmd_read  = mode_q;
  assign icb_cmd_wdata = (mode_q == MODE_FILL) ? iss_data : 32'h0;
  assign icb_cmd_wmask = icb_cmd_valid ? 4'hF : 4'h0;
  assign icb_rsp_ready = (state_q == ST_RUN) || (state_q == ST_DRAIN);

  assign cmd_hs   = icb_cmd_valid && icb_cmd_ready;
  assign rsp_hs   = icb_rsp_valid && icb_rsp_ready;
  assign rsp_fail = icb_rsp_err || ((mode_q == MODE_VERIFY) && (icb_rsp_rdata != ret_data));

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign err       = err_q;
  assign aborted   = aborted_q;
  assign err_addr  = err_addr_q;
  assign err_rdata = err_rdata_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      // An empty request still passes through DRAIN so done keeps the 2-cycle minimum.
      ST_IDLE:  if (start) state_d = (cfg_len != '0) ? ST_RUN : ST_DRAIN;
      ST_RUN:   if ((issued_q == len_q) || (abort && !hold_q)) state_d = ST_DRAIN;
      ST_DRAIN: if (outs_q == '0) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    outs_d = outs_q;
    case ({cmd_hs, rsp_hs})
      2'b10:   outs_d = outs_q + 1'b1;
      2'b01:   outs_d = outs_q - 1'b1;
      default: outs_d = outs_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_FILL;
      incr_q      <= 1'b0;
      base_q      <= '0;
      len_q       <= '0;
      pattern_q   <= '0;
      issued_q    <= '0;
      retired_q   <= '0;
      outs_q      <= '0;
      hold_q      <= 1'b0;
      err_q       <= 1'b0;
      aborted_q   <= 1'b0;
      err_addr_q  <= '0;
      err_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      outs_q  <= outs_d;
      hold_q  <= icb_cmd_valid && !icb_cmd_ready;
      if (cmd_hs) issued_q <= issued_q + 1'b1;
      if (rsp_hs) retired_q <= retired_q + 1'b1;
      if ((state_q == ST_RUN) && abort) aborted_q <= 1'b1;
      if (rsp_hs && rsp_fail && !err_q) begin
        err_q       <= 1'b1;
        err_addr_q  <= ret_addr;
        err_rdata_q <= (mode_q == MODE_VERIFY) ? icb_rsp_rdata : 32'h0;
      end
      if (start_acc) begin
        mode_q      <= cfg_mode;
        incr_q      <= cfg_incr;
        base_q      <= cfg_base & {{(AW-2){1'b1}}, 2'b00};
        len_q       <= cfg_len;
        pattern_q   <= cfg_pattern;
        issued_q    <= '0;
        retired_q   <= '0;
        err_q       <= 1'b0;
        aborted_q   <= 1'b0;
        err_addr_q  <= '0;
        err_rdata_q <= '0;
      end
    end
  end

endmodule
